bps_engine_seq: RTL and testbench
=================================

// Module: bps_engine_seq
// PURPOSE
//  Sequencing stage directly downstream of the BP-S master. Accepts one-cycle bps_opcode commands and walks the node index.
//  Each command issues per-node memory read/write transfers (LOAD/STORE_*) or datapath message-update starts (DOWN/UP).
//  Holds bps_stall high while a command is in progress; the master advances when it samples bps_stall low.
// PARAMETERS
//  NUM_NODES   16         nodes per chain; legal range 1..2**NODE_W
//  NODE_W      10         node index width
//  ADDR_W      32         memory address width
//  LOAD_BASE   32'h0000   base word address for LOAD reads
//  DOWN_BASE   32'h1000   base word address for STORE_DOWN writes
//  UP_BASE     32'h2000   base word address for STORE_UP writes
// PORTS
//  clk         in   1       single clock, all logic on posedge
//  rst         in   1       asynchronous, active-high reset
//  bps_opcode  in   3       0 IDLE,1 LOAD,2 DOWN,3 UP,4 STORE_DOWN,5 STORE_UP; valid one cycle
//  bps_stall   out  1       registered busy flag
//  mem_req     out  1       memory request, held until acknowledged
//  mem_we      out  1       1 = write (STORE_*), 0 = read (LOAD)
//  mem_addr    out  ADDR_W  base + node index
//  mem_ack     in   1       completes the request in the cycle it is high while mem_req=1
//  dp_start    out  1       one-cycle pulse: datapath computes node dp_node
//  dp_node     out  NODE_W  current node index
//  dp_dir      out  1       0 = downward, 1 = upward
//  dp_done     in   1       datapath finished current node
//  bps_err     out  1       sticky protocol-error flag
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, node=0. Reset mid-command aborts immediately; no handshake completes.
//  States IDLE, MEM, DP_ISSUE, DP_WAIT. Opcode sampled only in IDLE.
//  Accept at edge E: bps_stall=1 from E. Node = 0, except UP starts at NUM_NODES-1. Latch op.
//   LOAD/STORE_* -> MEM. DOWN/UP -> DP_ISSUE.
//  MEM: mem_req=1, mem_addr=base+node (zero-extended add, wraps mod 2**ADDR_W).
//   On mem_ack: last node -> IDLE and clear bps_stall, else node+1.
//   mem_ack while mem_req=0 is ignored.
//  DP_ISSUE: dp_start=1 for one cycle -> DP_WAIT. dp_done in the DP_ISSUE cycle is ignored.
//  DP_WAIT: on dp_done: last node -> IDLE and clear stall. Else node+1 (DOWN) or node-1 (UP) -> DP_ISSUE.
//   Last node is NUM_NODES-1 for DOWN and 0 for UP.
//  NUM_NODES=1: first node is also last; exactly one transfer or start.
//  Latency, ack tied high: opcode in cycle 0 -> mem_req cycles 1..N, bps_stall low from cycle N+1.
//  Latency, dp_done one cycle after dp_start: bps_stall low from cycle 2N+1.
//  Opcode 6/7 in IDLE: ignored, bps_err<=1. Non-IDLE opcode while busy: ignored, bps_err<=1.
//  bps_err clears only on reset.
//  Non-last transfer: bps_stall never drops between nodes.
// CONFIGURATION
//  BPS_PERF_CNT_EN defined:
//   Adds output perf_busy_cycles[31:0]: counts cycles with bps_stall=1, saturates at 32'hFFFFFFFF, reset 0.
//   Adds output perf_cmds[15:0]: accepted commands, wraps.
//  BPS_PERF_CNT_EN not defined: neither port nor counter exists; behaviour otherwise identical.
// STRUCTURE
//  Package bps_pkg: OP_* opcode encodings (shared with the master), state enum, ADDR/NODE width defaults.
//  Sub-module bps_node_counter: load first value, step +1/-1, is_last flag against NUM_NODES-1 or 0.
// TESTING
//  1. LOAD, N=4, mem_ack tied 1 -> reads at addr 0..3 in cycles 1..4, mem_we=0; bps_stall low cycle 5.
//  2. STORE_UP, mem_ack every 3rd cycle -> writes 0x2000..0x2003, mem_req held until each ack, mem_we=1.
//  3. UP, N=4, dp_done 1 cycle after start -> dp_node 3,2,1,0, dp_dir=1; stall low cycle 9.
//  4. DOWN with N=1 -> single dp_start for node 0; stall high exactly 2 cycles.
//  5. Opcode 7 in IDLE, then LOAD during DOWN -> both ignored, bps_err=1, DOWN completes normally.
//  6. Assert rst mid-STORE_DOWN -> outputs 0 asynchronously; a following LOAD starts at addr 0.
//     With BPS_PERF_CNT_EN: perf_cmds=1 after the following LOAD.

Source files
------------

// File: rtl/bps_pkg.sv
// bps_pkg: opcode encodings shared with the BP-S master, engine FSM states and width defaults.
package bps_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int NODE_W_DEF = 10;
    localparam logic [2:0] OP_IDLE       = 3'd0;
    localparam logic [2:0] OP_LOAD       = 3'd1;
    localparam logic [2:0] OP_DOWN       = 3'd2;
    localparam logic [2:0] OP_UP         = 3'd3;
    localparam logic [2:0] OP_STORE_DOWN = 3'd4;
    localparam logic [2:0] OP_STORE_UP   = 3'd5;
    typedef enum logic [1:0] {S_IDLE, S_MEM, S_DP_ISSUE, S_DP_WAIT} bps_state_e;
    function automatic logic op_valid(input logic [2:0] op);
        return op >= OP_LOAD && op <= OP_STORE_UP;
    endfunction
    function automatic logic op_is_mem(input logic [2:0] op);
        return op == OP_LOAD || op == OP_STORE_DOWN || op == OP_STORE_UP;
    endfunction
endpackage

// File: rtl/bps_engine_seq_if.sv
// bps_engine_seq_if: command, memory and datapath signals of the BP-S sequencing stage.
// The slave modport is the engine; the master modport is the BP-S master plus memory/datapath responders.
interface bps_engine_seq_if #(
    parameter int ADDR_W = bps_pkg::ADDR_W_DEF,
    parameter int NODE_W = bps_pkg::NODE_W_DEF
);
    logic [2:0]        bps_opcode;
    logic              bps_stall;
    logic              bps_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic              dp_start;
    logic [NODE_W-1:0] dp_node;
    logic              dp_dir;
    logic              dp_done;
    modport master (
        output bps_opcode, mem_ack, dp_done,
        input  bps_stall, bps_err, mem_req, mem_we, mem_addr, dp_start, dp_node, dp_dir
    );
    modport slave (
        input  bps_opcode, mem_ack, dp_done,
        output bps_stall, bps_err, mem_req, mem_we, mem_addr, dp_start, dp_node, dp_dir
    );
endinterface

// File: rtl/bps_node_counter.sv
// bps_node_counter: node index walker; loads the first node, steps +1 (down) or -1 (up), flags the last node.
module bps_node_counter #(
    parameter int NUM_NODES = 16,
    parameter int NODE_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              up,
    input  logic              step,
    output logic [NODE_W-1:0] node,
    output logic [NODE_W-1:0] nxt,
    output logic              dir,
    output logic              is_last
);
    localparam logic [NODE_W-1:0] LAST = NODE_W'(NUM_NODES - 1);
    always_comb nxt = load ? (up ? LAST : '0) : step ? (dir ? node - NODE_W'(1) : node + NODE_W'(1)) : node;
    assign is_last = dir ? (node == '0) : (node == LAST);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            node <= '0;
            dir  <= 1'b0;
        end else begin
            node <= nxt;
            if (load) dir <= up;
        end
endmodule

// File: rtl/bps_engine_seq.sv
// bps_engine_seq: sequences BP-S commands into per-node memory transfers or datapath starts.
// Optional BPS_PERF_CNT_EN adds perf_busy_cycles (saturating) and perf_cmds (wrapping) counters.
module bps_engine_seq
    import bps_pkg::*;
#(
    parameter int NUM_NODES = 16,
    parameter int NODE_W    = NODE_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] LOAD_BASE = 'h0000,
    parameter logic [ADDR_W-1:0] DOWN_BASE = 'h1000,
    parameter logic [ADDR_W-1:0] UP_BASE   = 'h2000
) (
    input logic             clk,
    input logic             rst,
    bps_engine_seq_if.slave bus
`ifdef BPS_PERF_CNT_EN
    ,
    output logic [31:0]     perf_busy_cycles,
    output logic [15:0]     perf_cmds
`endif
);
    bps_state_e        state;
    logic [2:0]        op;
    logic [NODE_W-1:0] nxt;
    logic              accept, last, step, mem_hs, dp_hs;
    logic [ADDR_W-1:0] base, addr_nxt;

    function automatic logic [ADDR_W-1:0] base_of(input logic [2:0] o);
        return o == OP_LOAD ? LOAD_BASE : o == OP_STORE_DOWN ? DOWN_BASE : UP_BASE;
    endfunction

    assign accept   = state == S_IDLE && op_valid(bus.bps_opcode);
    assign mem_hs   = state == S_MEM && bus.mem_req && bus.mem_ack;
    assign dp_hs    = state == S_DP_WAIT && bus.dp_done;
    assign step     = (mem_hs || dp_hs) && !last;
    // The opcode is not latched yet in the accept cycle, so the base comes straight from the bus then.
    assign base     = base_of(accept ? bus.bps_opcode : op);
    assign addr_nxt = base + ADDR_W'(nxt);

    bps_node_counter #(.NUM_NODES(NUM_NODES), .NODE_W(NODE_W)) u_cnt (
        .clk(clk),
        .rst(rst),
        .load(accept),
        .up(bus.bps_opcode == OP_UP),
        .step(step),
        .node(bus.dp_node),
        .nxt(nxt),
        .dir(bus.dp_dir),
        .is_last(last)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state         <= S_IDLE;
            op            <= OP_IDLE;
            bus.bps_stall <= 1'b0;
            bus.bps_err   <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.dp_start  <= 1'b0;
        end else begin
            bus.dp_start <= 1'b0;
            if (bus.bps_opcode != OP_IDLE && !accept) bus.bps_err <= 1'b1;
            case (state)
                S_IDLE: if (accept) begin
                    op            <= bus.bps_opcode;
                    bus.bps_stall <= 1'b1;
                    if (op_is_mem(bus.bps_opcode)) begin
                        state        <= S_MEM;
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= bus.bps_opcode != OP_LOAD;
                        bus.mem_addr <= addr_nxt;
                    end else begin
                        state        <= S_DP_ISSUE;
                        bus.dp_start <= 1'b1;
                    end
                end
                S_MEM: if (mem_hs) begin
                    if (last) begin
                        state         <= S_IDLE;
                        bus.bps_stall <= 1'b0;
                        bus.mem_req   <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= '0;
                    end else bus.mem_addr <= addr_nxt;
                end
                S_DP_ISSUE: state <= S_DP_WAIT;
                S_DP_WAIT: if (dp_hs) begin
                    if (last) begin
                        state         <= S_IDLE;
                        bus.bps_stall <= 1'b0;
                    end else begin
                        state        <= S_DP_ISSUE;
                        bus.dp_start <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end

`ifdef BPS_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            perf_busy_cycles <= '0;
            perf_cmds        <= '0;
        end else begin
            if (bus.bps_stall && perf_busy_cycles != '1) perf_busy_cycles <= perf_busy_cycles + 32'd1;
            if (accept) perf_cmds <= perf_cmds + 16'd1;
        end
`endif
endmodule

// File: tb/tb_bps_engine_seq.sv
// tb_bps_engine_seq: directed and randomized checks of bps_engine_seq against a per-command event list model.
module tb_bps_engine_seq;
    import bps_pkg::*;
    localparam int N = 4;

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [31:0] addr;
        logic [9:0]  node;
        bit          dir;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    ev_t  expq[$];

    always #5 clk = ~clk;

    bps_engine_seq_if #(.ADDR_W(32), .NODE_W(10)) bus ();
    bps_engine_seq_if #(.ADDR_W(32), .NODE_W(10)) bus1 ();

`ifdef BPS_PERF_CNT_EN
    logic [31:0] perf_busy, perf_busy1;
    logic [15:0] perf_cmds, perf_cmds1;
    bps_engine_seq #(.NUM_NODES(N)) dut (.clk(clk), .rst(rst), .bus(bus), .perf_busy_cycles(perf_busy), .perf_cmds(perf_cmds));
    bps_engine_seq #(.NUM_NODES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1), .perf_busy_cycles(perf_busy1), .perf_cmds(perf_cmds1));
`else
    bps_engine_seq #(.NUM_NODES(N)) dut (.clk(clk), .rst(rst), .bus(bus));
    bps_engine_seq #(.NUM_NODES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Expected transfer/start list for one command, straight from the opcode rules.
    task automatic build(input logic [2:0] op);
        expq.delete();
        for (int i = 0; i < N; i++) begin
            ev_t e;
            e.is_mem = op == OP_LOAD || op == OP_STORE_DOWN || op == OP_STORE_UP;
            e.we     = op == OP_STORE_DOWN || op == OP_STORE_UP;
            e.addr   = (op == OP_LOAD ? 32'h0 : op == OP_STORE_DOWN ? 32'h1000 : 32'h2000) + 32'(i);
            e.dir    = op == OP_UP;
            e.node   = 10'(op == OP_UP ? N - 1 - i : i);
            expq.push_back(e);
        end
    endtask

    // gap: idle cycles before each mem_ack, or cycles from dp_start to dp_done.
    task automatic run_cmd(input string tag, input logic [2:0] op, input int gap, input logic [2:0] intr);
        int  cyc_n = 0;
        int  wait_n = 0;
        int  dp_cnt = 0;
        ev_t e;
        build(op);
        bus.bps_opcode = op;
        bus.mem_ack    = 1'b0;
        bus.dp_done    = 1'b0;
        cyc();
        bus.bps_opcode = OP_IDLE;
        while (bus.bps_stall && cyc_n < 1000) begin
            cyc_n++;
            bus.bps_opcode = (cyc_n == 2) ? intr : OP_IDLE;
            bus.mem_ack    = bus.mem_req ? 1'b0 : 1'($urandom_range(0, 1));
            bus.dp_done    = 1'b0;
            if (bus.mem_req) begin
                bus.dp_done = 1'($urandom_range(0, 1));
                if (wait_n == gap) begin
                    bus.mem_ack = 1'b1;
                    wait_n = 0;
                    chk({tag, " mem pending"}, 64'(expq.size() != 0), 64'd1);
                    if (expq.size() != 0) begin
                        e = expq.pop_front();
                        chk({tag, " mem kind"}, 64'(e.is_mem), 64'd1);
                        chk({tag, " mem_we"}, 64'(bus.mem_we), 64'(e.we));
                        chk({tag, " mem_addr"}, 64'(bus.mem_addr), 64'(e.addr));
                    end
                end else wait_n++;
            end
            if (bus.dp_start) begin
                chk({tag, " dp pending"}, 64'(expq.size() != 0), 64'd1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk({tag, " dp kind"}, 64'(e.is_mem), 64'd0);
                    chk({tag, " dp_node"}, 64'(bus.dp_node), 64'(e.node));
                    chk({tag, " dp_dir"}, 64'(bus.dp_dir), 64'(e.dir));
                end
                dp_cnt = gap;
                bus.dp_done = 1'($urandom_range(0, 1));
            end else if (dp_cnt > 0) begin
                dp_cnt--;
                if (dp_cnt == 0) bus.dp_done = 1'b1;
            end
            cyc();
        end
        bus.bps_opcode = OP_IDLE;
        bus.mem_ack    = 1'b0;
        bus.dp_done    = 1'b0;
        chk({tag, " stall cycles"}, 64'(cyc_n), 64'(N * (gap + 1)));
        chk({tag, " events left"}, 64'(expq.size()), 64'd0);
        chk({tag, " req after"}, 64'(bus.mem_req), 64'd0);
        chk({tag, " bps_err"}, 64'(bus.bps_err), 64'(intr != OP_IDLE));
    endtask

    initial begin
        logic [2:0] op;
        int         gap;
        bus.bps_opcode  = OP_IDLE;
        bus.mem_ack     = 1'b0;
        bus.dp_done     = 1'b0;
        bus1.bps_opcode = OP_IDLE;
        bus1.mem_ack    = 1'b0;
        bus1.dp_done    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst stall", 64'(bus.bps_stall), 64'd0);
        chk("rst req", 64'(bus.mem_req), 64'd0);
        chk("rst we", 64'(bus.mem_we), 64'd0);
        chk("rst addr", 64'(bus.mem_addr), 64'd0);
        chk("rst start", 64'(bus.dp_start), 64'd0);
        chk("rst node", 64'(bus.dp_node), 64'd0);
        chk("rst dir", 64'(bus.dp_dir), 64'd0);
        chk("rst err", 64'(bus.bps_err), 64'd0);
        @(negedge clk) rst = 1'b0;
        cyc();
        // Stray acknowledges while idle must not start anything.
        bus.mem_ack = 1'b1;
        bus.dp_done = 1'b1;
        cyc();
        cyc();
        chk("idle ack req", 64'(bus.mem_req), 64'd0);
        chk("idle ack stall", 64'(bus.bps_stall), 64'd0);
        bus.mem_ack = 1'b0;
        bus.dp_done = 1'b0;
        run_cmd("load", OP_LOAD, 0, OP_IDLE);
        run_cmd("store_up", OP_STORE_UP, 2, OP_IDLE);
        run_cmd("up", OP_UP, 1, OP_IDLE);
        run_cmd("down", OP_DOWN, 2, OP_IDLE);
        run_cmd("store_down", OP_STORE_DOWN, 1, OP_IDLE);
        // Single-node engine: one start, stall high exactly two cycles; one transfer for LOAD.
        bus1.bps_opcode = OP_DOWN;
        cyc();
        bus1.bps_opcode = OP_IDLE;
        chk("n1 start c1", 64'(bus1.dp_start), 64'd1);
        chk("n1 node c1", 64'(bus1.dp_node), 64'd0);
        chk("n1 stall c1", 64'(bus1.bps_stall), 64'd1);
        cyc();
        bus1.dp_done = 1'b1;
        chk("n1 start c2", 64'(bus1.dp_start), 64'd0);
        chk("n1 stall c2", 64'(bus1.bps_stall), 64'd1);
        cyc();
        bus1.dp_done = 1'b0;
        chk("n1 stall c3", 64'(bus1.bps_stall), 64'd0);
        chk("n1 start c3", 64'(bus1.dp_start), 64'd0);
        cyc();
        chk("n1 start c4", 64'(bus1.dp_start), 64'd0);
        bus1.bps_opcode = OP_LOAD;
        bus1.mem_ack    = 1'b1;
        cyc();
        bus1.bps_opcode = OP_IDLE;
        chk("n1 load req", 64'(bus1.mem_req), 64'd1);
        chk("n1 load addr", 64'(bus1.mem_addr), 64'd0);
        cyc();
        chk("n1 load req end", 64'(bus1.mem_req), 64'd0);
        chk("n1 load stall end", 64'(bus1.bps_stall), 64'd0);
        bus1.mem_ack = 1'b0;
        for (int k = 0; k < 10; k++) begin
            op  = 3'($urandom_range(1, 5));
            gap = int'($urandom_range(3, (op == OP_DOWN || op == OP_UP) ? 1 : 0));
            run_cmd($sformatf("rand%0d op%0d", k, op), op, gap, OP_IDLE);
        end
        // Illegal opcode in IDLE: ignored, sticky error that survives until reset.
        bus.bps_opcode = 3'd7;
        cyc();
        bus.bps_opcode = OP_IDLE;
        cyc();
        chk("op7 err", 64'(bus.bps_err), 64'd1);
        chk("op7 stall", 64'(bus.bps_stall), 64'd0);
        cyc();
        cyc();
        chk("op7 err sticky", 64'(bus.bps_err), 64'd1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        cyc();
        chk("err cleared", 64'(bus.bps_err), 64'd0);
        run_cmd("down intr load", OP_DOWN, 1, OP_LOAD);
        // Asynchronous reset in the middle of a STORE_DOWN.
        bus.bps_opcode = OP_STORE_DOWN;
        cyc();
        bus.bps_opcode = OP_IDLE;
        bus.mem_ack    = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        chk("sd addr before rst", 64'(bus.mem_addr), 64'h1001);
        #2 rst = 1'b1;
        #1;
        chk("async rst req", 64'(bus.mem_req), 64'd0);
        chk("async rst stall", 64'(bus.bps_stall), 64'd0);
        chk("async rst addr", 64'(bus.mem_addr), 64'd0);
        chk("async rst we", 64'(bus.mem_we), 64'd0);
        chk("async rst node", 64'(bus.dp_node), 64'd0);
        chk("async rst err", 64'(bus.bps_err), 64'd0);
        @(negedge clk) rst = 1'b0;
        cyc();
        run_cmd("load after rst", OP_LOAD, 0, OP_IDLE);
`ifdef BPS_PERF_CNT_EN
        chk("perf cmds", 64'(perf_cmds), 64'd1);
        chk("perf busy", 64'(perf_busy), 64'(N));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
